molecule_agent: RTL

- Self-contained, parametrised osmosis molecule. Owns its position, its motion state machine and its membrane-permeability decision.
- Draws itself as a MOL_SIZE square against the VGA h_cnt/v_cnt scan.
- Generalises the fixed-colour molecule: colour, size, start point, velocity, arena bounds and membrane location are all parameters.
- Adds wall and membrane bouncing, side tracking and a crossing counter. One instance per molecule; the top level ORs is_molecule and uses COLOR for pixel colour.

---
 rtl/molecule_agent_if.sv | 37 +++
 rtl/molecule_agent.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/molecule_agent_if.sv
// molecule_agent_if: scan, membrane controls and sprite outputs
// master drives scan/controls, slave is the molecule itself
interface molecule_agent_if;
  logic       frame;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       magenta_membrane;
  logic       red_membrane;
  logic       blue_membrane;
  logic       no_membrane;
  logic       membrane_on;
  logic       freeze;
  logic       btnD;
  logic       is_molecule;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       side;
  logic [7:0] crossings;

  modport master (
    output frame, h_cnt, v_cnt,
    output magenta_membrane, red_membrane,
    output blue_membrane, no_membrane,
    output membrane_on, freeze, btnD,
    input  is_molecule, pos_x, pos_y,
    input  side, crossings
  );

  modport slave (
    input  frame, h_cnt, v_cnt,
    input  magenta_membrane, red_membrane,
    input  blue_membrane, no_membrane,
    input  membrane_on, freeze, btnD,
    output is_molecule, pos_x, pos_y,
    output side, crossings
  );
endinterface

// File: rtl/molecule_agent.sv
// molecule_agent: bouncing osmosis sprite with membrane decision
// tracks which side of the band it is on and counts crossings
module molecule_agent #(
  parameter int MOL_SIZE   = 16,
  parameter int COLOR      = 1,
  parameter int START_X    = 100,
  parameter int START_Y    = 200,
  parameter int VEL_X      = 2,
  parameter int VEL_Y      = 1,
  parameter int ARENA_L    = 0,
  parameter int ARENA_R    = 640,
  parameter int ARENA_T    = 0,
  parameter int ARENA_B    = 480,
  parameter int MEMBRANE_X = 318,
  parameter int MEMBRANE_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  molecule_agent_if.slave bus
);

  typedef enum logic [1:0] {
    RUN,
    FROZEN,
    RESPAWN
  } state_t;

  localparam logic signed [11:0] SZ = 12'(MOL_SIZE);
  localparam logic signed [11:0] HALF = 12'(MOL_SIZE / 2);
  localparam logic signed [11:0] VX = 12'(VEL_X);
  localparam logic signed [11:0] VY = 12'(VEL_Y);
  localparam logic signed [11:0] AL = 12'(ARENA_L);
  localparam logic signed [11:0] AR = 12'(ARENA_R);
  localparam logic signed [11:0] AT = 12'(ARENA_T);
  localparam logic signed [11:0] AB = 12'(ARENA_B);
  localparam logic signed [11:0] ML = 12'(MEMBRANE_X);
  localparam logic signed [11:0] MR =
    12'(MEMBRANE_X + MEMBRANE_W);
  localparam logic signed [11:0] MID =
    12'(MEMBRANE_X + MEMBRANE_W / 2);
  localparam logic [9:0] SX = 10'(START_X);
  localparam logic [9:0] SY = 10'(START_Y);
  localparam logic SIDE0 =
    (START_X + MOL_SIZE / 2) >= (MEMBRANE_X + MEMBRANE_W / 2);

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       dir_x_q, dir_x_d;
  logic       dir_y_q, dir_y_d;
  logic       side_q, side_d;
  logic [7:0] crossings_q, crossings_d;
  logic       btn_q, btn_d;

  logic signed [11:0] px, py;
  logic signed [11:0] cx, cy;
  logic signed [11:0] nx;
  logic               ndx, ndy;
  logic               perm, cur_ov, btn_rise, cross_clr;

  assign px = $signed({2'b00, x_q});
  assign py = $signed({2'b00, y_q});
  assign btn_rise = bus.btnD & ~btn_q;

  assign perm = bus.no_membrane
              | ~bus.membrane_on
              | (bus.magenta_membrane & (COLOR != 2))
              | (bus.red_membrane & (COLOR == 1))
              | (bus.blue_membrane & (COLOR == 0));

  assign cur_ov = (px < MR) && (px + SZ > ML);

  // x step: wall clamp first, then bounce off an impermeable band
  always_comb begin
    cx  = dir_x_q ? px - VX : px + VX;
    ndx = dir_x_q;
    if (cx < AL) begin
      cx  = AL;
      ndx = ~dir_x_q;
    end else if (cx + SZ > AR) begin
      cx  = AR - SZ;
      ndx = ~dir_x_q;
    end
    nx = cx;
    if (!perm && !cur_ov && (cx < MR) && (cx + SZ > ML)) begin
      if (px + SZ <= ML) begin
        nx  = ML - SZ;
        ndx = 1'b1;
      end else begin
        nx  = MR;
        ndx = 1'b0;
      end
    end
  end

  // y step: walls only
  always_comb begin
    cy  = dir_y_q ? py - VY : py + VY;
    ndy = dir_y_q;
    if (cy < AT) begin
      cy  = AT;
      ndy = ~dir_y_q;
    end else if (cy + SZ > AB) begin
      cy  = AB - SZ;
      ndy = ~dir_y_q;
    end
  end

  // next-state: respawn edge beats freeze beats motion
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    cross_clr = 1'b0;
    btn_d     = bus.btnD;
    unique case (state_q)
      RUN: begin
        if (btn_rise) begin
          state_d = RESPAWN;
        end else if (bus.freeze) begin
          state_d = FROZEN;
        end else if (bus.frame) begin
          x_d     = nx[9:0];
          y_d     = cy[9:0];
          dir_x_d = ndx;
          dir_y_d = ndy;
        end
      end
      FROZEN: begin
        if (btn_rise) begin
          state_d = RESPAWN;
        end else if (!bus.freeze) begin
          state_d = RUN;
        end
      end
      RESPAWN: begin
        if (bus.frame) begin
          x_d       = SX;
          y_d       = SY;
          dir_x_d   = 1'b0;
          dir_y_d   = 1'b0;
          cross_clr = 1'b1;
          state_d   = bus.freeze ? FROZEN : RUN;
        end
      end
      default: state_d = RUN;
    endcase
    side_d = ($signed({2'b00, x_d}) + HALF) >= MID;
    if (cross_clr) begin
      crossings_d = '0;
    end else if ((side_d != side_q) && (crossings_q != 8'hFF)) begin
      crossings_d = crossings_q + 8'd1;
    end else begin
      crossings_d = crossings_q;
    end
  end

  // state, position and counters register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      x_q         <= SX;
      y_q         <= SY;
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      side_q      <= SIDE0;
      crossings_q <= '0;
      btn_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      side_q      <= side_d;
      crossings_q <= crossings_d;
      btn_q       <= btn_d;
    end
  end

  logic [10:0] x_end, y_end;
  assign x_end = {1'b0, x_q} + 11'(MOL_SIZE);
  assign y_end = {1'b0, y_q} + 11'(MOL_SIZE);

  assign bus.is_molecule = (bus.h_cnt >= x_q)
                         && ({1'b0, bus.h_cnt} < x_end)
                         && (bus.v_cnt >= y_q)
                         && ({1'b0, bus.v_cnt} < y_end);
  assign bus.pos_x     = x_q;
  assign bus.pos_y     = y_q;
  assign bus.side      = side_q;
  assign bus.crossings = crossings_q;

endmodule
